// File: rtl/cpu_timing_gen.sv
// One-hot beat generator (T0..T[NUM_BEATS-1]) for the model CPU control unit.
// Optional single-instruction stepping is compiled in with `define SINGLE_STEP_EN.
module cpu_timing_gen #(
  parameter int NUM_BEATS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 START,
  input  logic                 STEP,
  input  logic                 HALT_REQ,
  output logic [NUM_BEATS-1:0] T,
  output logic                 RUN,
  output logic                 HALTED,
  output logic                 CYC_END,
  output logic [CNT_W-1:0]     INSTR_CNT
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [NUM_BEATS-1:0] T_ZERO  = {NUM_BEATS{1'b0}};
  localparam logic [NUM_BEATS-1:0] T_FIRST = {{(NUM_BEATS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [NUM_BEATS-1:0] t_q, t_d;
  logic                 halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 run_q, run_d;
  logic                 halted_q, halted_d;
  logic                 cyc_end_q, cyc_end_d;

`ifndef SINGLE_STEP_EN
  logic step_unused_s;
  assign step_unused_s = STEP;
`endif

  // Next-state, beat, halt-pending and counter logic.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    halt_pend_d = halt_pend_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        t_d         = T_ZERO;
        halt_pend_d = 1'b0;
        if (START) begin
          state_d = S_RUN;
          t_d     = T_FIRST;
        end
`ifdef SINGLE_STEP_EN
        else if (STEP) begin
          state_d = S_STEP;
          t_d     = T_FIRST;
        end
`endif
        else begin
          state_d = S_IDLE;
        end
      end
`ifdef SINGLE_STEP_EN
      S_RUN, S_STEP: begin
`else
      S_RUN: begin
`endif
        // Leaving the last beat completes the instruction; halts only take effect here.
        if (t_q[NUM_BEATS-1]) begin
          cnt_d       = cnt_q + CNT_ONE;
          halt_pend_d = 1'b0;
          if (halt_pend_q || HALT_REQ) begin
            state_d = S_HALTED;
            t_d     = T_ZERO;
          end
`ifdef SINGLE_STEP_EN
          else if (state_q == S_STEP) begin
            state_d = S_IDLE;
            t_d     = T_ZERO;
          end
`endif
          else begin
            t_d = T_FIRST;
          end
        end else begin
          t_d         = {t_q[NUM_BEATS-2:0], 1'b0};
          halt_pend_d = halt_pend_q | HALT_REQ;
        end
      end
      S_HALTED: begin
        state_d     = S_HALTED;
        t_d         = T_ZERO;
        halt_pend_d = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        t_d         = T_ZERO;
        halt_pend_d = 1'b0;
      end
    endcase
  end

  // Status outputs follow the next state so they register alongside T.
  always_comb begin
    run_d     = (state_d == S_RUN) || (state_d == S_STEP);
    halted_d  = (state_d == S_HALTED);
    cyc_end_d = t_d[NUM_BEATS-1];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      t_q         <= T_ZERO;
      halt_pend_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      run_q       <= 1'b0;
      halted_q    <= 1'b0;
      cyc_end_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      halt_pend_q <= halt_pend_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      halted_q    <= halted_d;
      cyc_end_q   <= cyc_end_d;
    end
  end

  assign T         = t_q;
  assign RUN       = run_q;
  assign HALTED    = halted_q;
  assign CYC_END   = cyc_end_q;
  assign INSTR_CNT = cnt_q;

endmodule
